nwc_pointwise_alu: RTL and testbench

Parametrised pointwise coefficient engine for the NTT-domain negacyclic convolution path. It streams two polynomials out of dual-port coefficient memory, row by row with LANES coefficients per row, and combines them coefficient-wise modulo Q. The op is multiply, add or subtract. It writes the result back through the same byte-addressed memory interface and signals completion. It generalises the fixed two-lane up/down datapath to LANES lanes, configurable modulus, configurable memory latency and selectable op.

---
 rtl/nwc_pointwise_alu.sv | 178 +++++++++++++++++
 tb/tb_nwc_pointwise_alu.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nwc_pointwise_alu.sv
// rtl/nwc_pointwise_alu.sv - pointwise mod-Q mul/add/sub engine over dual-port coefficient memory
//
// Streams ROWS = N/LANES rows of operand A and B, combines each lane modulo Q
// and writes the result rows back. Every lane shares one control pipeline.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   start, op           begin a pass (IDLE only); op 0=mul 1=add 2=sub 3=mul
//   start_ready         high while idle
//   addrr               read byte address (row*4)
//   data_in0, data_in1  operand rows, valid RD_LAT cycles after addrr
//   addrw, data_out     write byte address and result row
//   out_wen             byte write enable, 4'hF on write cycles
//   output_ready        one-cycle completion pulse
//   memory_writable     high once the input memories are no longer read
module nwc_pointwise_alu #(
    parameter int              N       = 4096,
    parameter int              LANES   = 2,
    parameter int              W       = 32,
    parameter longint unsigned Q       = 12289,
    parameter int              RD_LAT  = 1,
    parameter int              ALU_LAT = 3,
    parameter int              ADDR_W  = $clog2(N / LANES) + 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [1:0]           op,
    output logic                 start_ready,
    output logic [ADDR_W-1:0]    addrr,
    input  logic [LANES*W-1:0]   data_in0,
    input  logic [LANES*W-1:0]   data_in1,
    output logic [ADDR_W-1:0]    addrw,
    output logic [LANES*W-1:0]   data_out,
    output logic [3:0]           out_wen,
    output logic                 output_ready,
    output logic                 memory_writable
);

    localparam int                ROWS      = N / LANES;
    localparam int                ROW_W     = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'((ROWS - 1) * 4);
    localparam logic [W:0]        Q1        = (W + 1)'(Q);
    localparam logic [2*W-1:0]    Q2        = (2 * W)'(Q);

    typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

    state_t          state;
    logic [ROW_W-1:0] row;
    logic [1:0]      op_q;

    // Read-side alignment: valid/address delayed to meet the memory data.
    logic [RD_LAT-1:0]  rd_vld;
    logic [ADDR_W-1:0]  rd_addr [RD_LAT];

    // Arithmetic pipeline; the last stage drives the write port directly.
    logic [ALU_LAT-1:0] alu_vld;
    logic [ADDR_W-1:0]  alu_addr [ALU_LAT];
    logic [LANES*W-1:0] alu_data [ALU_LAT];
    logic [LANES*W-1:0] res;

    assign addrr           = ADDR_W'({row, 2'b00});
    assign out_wen         = alu_vld[ALU_LAT-1] ? 4'hF : 4'h0;
    assign addrw           = alu_addr[ALU_LAT-1];
    assign data_out        = alu_data[ALU_LAT-1];
    assign memory_writable = (state != READ) && (rd_vld == '0);

    // Add/sub assume a, b < Q; mul reduces the full product so any inputs work.
    function automatic logic [W-1:0] lane_op(input logic [1:0] o,
                                             input logic [W-1:0] a,
                                             input logic [W-1:0] b);
        logic [2*W-1:0] prod;
        logic [W:0]     sum;
        logic [W:0]     diff;
        prod = {{W{1'b0}}, a} * {{W{1'b0}}, b};
        sum  = {1'b0, a} + {1'b0, b};
        diff = {1'b0, a} - {1'b0, b};
        case (o)
            2'd1:    lane_op = (sum >= Q1) ? W'(sum - Q1) : W'(sum);
            // diff has wrapped when a < b; adding Q brings it back into range
            2'd2:    lane_op = (a < b) ? W'(diff + Q1) : W'(diff);
            default: lane_op = W'(prod % Q2);
        endcase
    endfunction

    // Combinational datapath; the ALU_LAT register stages behind it are
    // intended to be retimed into the multiply/reduce logic by synthesis.
    always_comb begin
        res = '0;
        for (int l = 0; l < LANES; l++) begin
            res[l*W +: W] = lane_op(op_q, data_in0[l*W +: W], data_in1[l*W +: W]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            row          <= '0;
            op_q         <= 2'd0;
            start_ready  <= 1'b1;
            output_ready <= 1'b0;
        end else begin
            output_ready <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state       <= READ;
                        op_q        <= op;
                        row         <= '0;
                        start_ready <= 1'b0;
                    end
                end
                READ: begin
                    if (row == ROW_W'(ROWS - 1)) begin
                        state <= DRAIN;
                    end else begin
                        row <= row + ROW_W'(1);
                    end
                end
                DRAIN: begin
                    // The final write carries the last row address.
                    if (out_wen != 4'h0 && addrw == LAST_ADDR) begin
                        state        <= DONE;
                        output_ready <= 1'b1;
                    end
                end
                DONE: begin
                    state       <= IDLE;
                    row         <= '0;
                    start_ready <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_vld <= '0;
            for (int k = 0; k < RD_LAT; k++) begin
                rd_addr[k] <= '0;
            end
        end else begin
            rd_vld[0]  <= (state == READ);
            rd_addr[0] <= addrr;
            for (int k = 1; k < RD_LAT; k++) begin
                rd_vld[k]  <= rd_vld[k-1];
                rd_addr[k] <= rd_addr[k-1];
            end
        end
    end

    // Address/data stages load only with valid data so the write port holds
    // its last value between passes.
    always_ff @(posedge clk) begin
        if (rst) begin
            alu_vld <= '0;
            for (int k = 0; k < ALU_LAT; k++) begin
                alu_addr[k] <= '0;
                alu_data[k] <= '0;
            end
        end else begin
            alu_vld[0] <= rd_vld[RD_LAT-1];
            if (rd_vld[RD_LAT-1]) begin
                alu_addr[0] <= rd_addr[RD_LAT-1];
                alu_data[0] <= res;
            end
            for (int k = 1; k < ALU_LAT; k++) begin
                alu_vld[k] <= alu_vld[k-1];
                if (alu_vld[k-1]) begin
                    alu_addr[k] <= alu_addr[k-1];
                    alu_data[k] <= alu_data[k-1];
                end
            end
        end
    end

endmodule

// File: tb/tb_nwc_pointwise_alu.sv
// tb/tb_nwc_pointwise_alu.sv - directed bench for nwc_pointwise_alu (default and 4-lane configs)
module tb_nwc_pointwise_alu;

    localparam longint unsigned Q = 12289;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int passed = 0;
    int total  = 0;
    int fails  = 0;

    logic rst;

    // Default instance: N=4096, LANES=2, RD_LAT=1, ALU_LAT=3
    logic        a_start, a_start_ready, a_ordy, a_mw;
    logic [1:0]  a_op;
    logic [12:0] a_addrr, a_addrw;
    logic [63:0] a_din0, a_din1, a_dout;
    logic [3:0]  a_wen;
    int          a_mode;

    nwc_pointwise_alu dut_a (
        .clk(clk), .rst(rst), .start(a_start), .op(a_op), .start_ready(a_start_ready),
        .addrr(a_addrr), .data_in0(a_din0), .data_in1(a_din1), .addrw(a_addrw),
        .data_out(a_dout), .out_wen(a_wen), .output_ready(a_ordy), .memory_writable(a_mw)
    );

    // Small instance: N=64, LANES=4, RD_LAT=2, ALU_LAT=2
    logic         b_start, b_start_ready, b_ordy, b_mw;
    logic [1:0]   b_op;
    logic [5:0]   b_addrr, b_addrw;
    logic [127:0] b_din0, b_din1, b_dout, b_m0, b_m1;
    logic [3:0]   b_wen;
    int           b_mode;

    nwc_pointwise_alu #(.N(64), .LANES(4), .RD_LAT(2), .ALU_LAT(2)) dut_b (
        .clk(clk), .rst(rst), .start(b_start), .op(b_op), .start_ready(b_start_ready),
        .addrr(b_addrr), .data_in0(b_din0), .data_in1(b_din1), .addrw(b_addrw),
        .data_out(b_dout), .out_wen(b_wen), .output_ready(b_ordy), .memory_writable(b_mw)
    );

    function automatic logic [31:0] opa(input int mode, input int idx);
        case (mode)
            2:       return 32'd12288;
            3:       return 32'hFFFF_FFFF - 32'(idx * 977);
            default: return 32'(idx);
        endcase
    endfunction

    function automatic logic [31:0] opb(input int mode, input int idx);
        case (mode)
            1:       return 32'(idx + 1);
            2:       return 32'd12288;
            3:       return 32'(idx * 7919 + 3);
            default: return 32'(idx);
        endcase
    endfunction

    function automatic logic [31:0] ref_op(input int o, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] x;
        case (o)
            1:       x = ({32'b0, a} + {32'b0, b}) % Q;
            2:       x = ({32'b0, a} + Q - {32'b0, b}) % Q;
            default: x = ({32'b0, a} * {32'b0, b}) % Q;
        endcase
        return x[31:0];
    endfunction

    // Memories: A has one register stage, B has two.
    always @(posedge clk) begin
        for (int l = 0; l < 2; l++) begin
            a_din0[l*32 +: 32] <= opa(a_mode, int'(a_addrr >> 2) + l * 2048);
            a_din1[l*32 +: 32] <= opb(a_mode, int'(a_addrr >> 2) + l * 2048);
        end
        for (int l = 0; l < 4; l++) begin
            b_m0[l*32 +: 32] <= opa(b_mode, int'(b_addrr >> 2) + l * 16);
            b_m1[l*32 +: 32] <= opb(b_mode, int'(b_addrr >> 2) + l * 16);
        end
        b_din0 <= b_m0;
        b_din1 <= b_m1;
    end

    // Write-port monitors
    int a_wr_cnt = 0, a_ord_err = 0, a_ordy_cnt = 0, a_seq = 0;
    int a_first = 0, a_ordy_cyc = 0, a_mw_rise = 0, a_last = 0;
    logic a_mw_prev = 1'b1;
    logic [63:0] a_res [2048];

    always @(negedge clk) begin
        if (a_wen != 4'h0) begin
            if (a_wen != 4'hF || a_addrw != 13'(a_seq * 4)) a_ord_err++;
            if (a_seq == 0) a_first = cyc;
            a_last = cyc;
            a_res[a_addrw >> 2] = a_dout;
            a_seq++;
            a_wr_cnt++;
        end
        if (a_ordy) begin
            a_ordy_cnt++;
            a_ordy_cyc = cyc;
            a_seq = 0;
        end
        if (rst) a_seq = 0;
        if (a_mw && !a_mw_prev) a_mw_rise = cyc;
        a_mw_prev = a_mw;
    end

    int b_wr_cnt = 0, b_ord_err = 0, b_ordy_cnt = 0, b_seq = 0;
    int b_first = 0, b_ordy_cyc = 0, b_mw_rise = 0;
    logic b_mw_prev = 1'b1;
    logic [127:0] b_res [16];

    always @(negedge clk) begin
        if (b_wen != 4'h0) begin
            if (b_wen != 4'hF || b_addrw != 6'(b_seq * 4)) b_ord_err++;
            if (b_seq == 0) b_first = cyc;
            b_res[b_addrw >> 2] = b_dout;
            b_seq++;
            b_wr_cnt++;
        end
        if (b_ordy) begin
            b_ordy_cnt++;
            b_ordy_cyc = cyc;
            b_seq = 0;
        end
        if (rst) b_seq = 0;
        if (b_mw && !b_mw_prev) b_mw_rise = cyc;
        b_mw_prev = b_mw;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int scan_a(input int mode, input int o);
        int errs = 0;
        for (int r = 0; r < 2048; r++) begin
            for (int l = 0; l < 2; l++) begin
                if (a_res[r][l*32 +: 32] !== ref_op(o, opa(mode, r + l * 2048), opb(mode, r + l * 2048)))
                    errs++;
            end
        end
        return errs;
    endfunction

    function automatic int scan_b(input int mode, input int o);
        int errs = 0;
        for (int r = 0; r < 16; r++) begin
            for (int l = 0; l < 4; l++) begin
                if (b_res[r][l*32 +: 32] !== ref_op(o, opa(mode, r + l * 16), opb(mode, r + l * 16)))
                    errs++;
            end
        end
        return errs;
    endfunction

    task automatic go_a(input logic [1:0] o, output int s);
        @(negedge clk);
        a_op = o; a_start = 1'b1; s = cyc;
        @(negedge clk);
        a_start = 1'b0;
    endtask

    task automatic go_b(input logic [1:0] o, output int s);
        @(negedge clk);
        b_op = o; b_start = 1'b1; s = cyc;
        @(negedge clk);
        b_start = 1'b0;
    endtask

    task automatic wait_a(input int base, input string tag);
        int n = 0;
        while (a_ordy_cnt == base && n < 4000) begin
            @(posedge clk);
            n++;
        end
        chk(tag, 64'(a_ordy_cnt != base), 1);
    endtask

    task automatic wait_b(input int base, input string tag);
        int n = 0;
        while (b_ordy_cnt == base && n < 200) begin
            @(posedge clk);
            n++;
        end
        chk(tag, 64'(b_ordy_cnt != base), 1);
    endtask

    int s, wb, ob, rb;

    initial begin
        rst = 1'b1;
        a_start = 1'b0; a_op = 2'd0; a_mode = 0;
        b_start = 1'b0; b_op = 2'd0; b_mode = 0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_start_ready", a_start_ready, 1);
        chk("rst_mw", a_mw, 1);
        chk("rst_ordy", a_ordy, 0);
        chk("rst_wen", a_wen, 0);
        chk("rst_addrr", a_addrr, 0);
        chk("rst_addrw", a_addrw, 0);
        chk("rst_dout", a_dout, 0);
        chk("rst_b_ready", b_start_ready, 1);

        // Pass 1: mul, A=B=coefficient index
        a_mode = 0; wb = a_wr_cnt; ob = a_ord_err; rb = a_ordy_cnt;
        go_a(2'd0, s);
        chk("mul_busy", a_start_ready, 0);
        chk("mul_addrr_r0", a_addrr, 0);
        chk("mul_mw_busy", a_mw, 0);
        repeat (5) @(negedge clk);
        chk("mul_addrr_r5", a_addrr, 20);
        wait_a(rb, "mul_done");
        chk("mul_wr_cnt", 64'(a_wr_cnt - wb), 2048);
        chk("mul_order", 64'(a_ord_err - ob), 0);
        chk("mul_first_wr", 64'(a_first), 64'(s + 5));
        chk("mul_last_wr", 64'(a_last), 64'(s + 2052));
        chk("mul_ordy_cyc", 64'(a_ordy_cyc), 64'(s + 2053));
        chk("mul_mw_rise", 64'(a_mw_rise), 64'(s + 2050));
        chk("mul_r5_l0", a_res[5][31:0], 25);
        chk("mul_r5_l1", a_res[5][63:32], 11971);
        chk("mul_r2047_l0", a_res[2047][31:0], 11949);
        chk("mul_r2047_l1", a_res[2047][63:32], 6829);
        chk("mul_all", 64'(scan_a(0, 0)), 0);
        repeat (3) @(posedge clk);
        chk("mul_ordy_once", 64'(a_ordy_cnt - rb), 1);

        // Pass 2: sub, A=r B=r+1 gives Q-1 everywhere
        a_mode = 1; rb = a_ordy_cnt;
        go_a(2'd2, s);
        wait_a(rb, "sub_done");
        chk("sub_r0", a_res[0][31:0], 12288);
        chk("sub_r2047_l1", a_res[2047][63:32], 12288);
        chk("sub_all", 64'(scan_a(1, 2)), 0);

        // Pass 3: add, A=B=Q-1 gives Q-2 everywhere
        a_mode = 2; rb = a_ordy_cnt;
        go_a(2'd1, s);
        wait_a(rb, "add_done");
        chk("add_r100", a_res[100][31:0], 12287);
        chk("add_all", 64'(scan_a(2, 1)), 0);

        // Start held high, op toggled mid-pass
        a_mode = 0; rb = a_ordy_cnt; wb = a_wr_cnt;
        @(negedge clk);
        a_op = 2'd0; a_start = 1'b1; s = cyc;
        repeat (10) @(negedge clk);
        a_op = 2'd1;
        wait_a(rb, "hold_done1");
        chk("hold_one_pass_wr", 64'(a_wr_cnt - wb), 2048);
        chk("hold_ordy_cyc", 64'(a_ordy_cyc), 64'(s + 2053));
        chk("hold_op_latched", a_res[5][63:32], 11971);
        chk("hold_mul_all", 64'(scan_a(0, 0)), 0);
        repeat (20) @(negedge clk);
        a_start = 1'b0;
        wait_a(rb + 1, "hold_done2");
        chk("hold_restart_first", 64'(a_first), 64'(s + 2054 + 5));
        chk("hold_add_r5_l0", a_res[5][31:0], 10);
        chk("hold_add_r5_l1", a_res[5][63:32], 4106);
        chk("hold_add_all", 64'(scan_a(0, 1)), 0);
        repeat (30) @(posedge clk);
        chk("hold_two_passes", 64'(a_ordy_cnt - rb), 2);

        // Reset at s+100 for one cycle
        a_mode = 0; rb = a_ordy_cnt;
        go_a(2'd0, s);
        while (cyc < s + 100) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mrst_wen", a_wen, 0);
        chk("mrst_addrw", a_addrw, 0);
        chk("mrst_dout", a_dout, 0);
        chk("mrst_addrr", a_addrr, 0);
        chk("mrst_start_ready", a_start_ready, 1);
        chk("mrst_mw", a_mw, 1);
        chk("mrst_ordy", a_ordy, 0);
        wb = a_wr_cnt;
        repeat (20) @(posedge clk);
        chk("mrst_no_writes", 64'(a_wr_cnt - wb), 0);
        chk("mrst_no_ordy", 64'(a_ordy_cnt - rb), 0);
        a_mode = 3; rb = a_ordy_cnt; wb = a_wr_cnt; ob = a_ord_err;
        go_a(2'd0, s);
        wait_a(rb, "post_rst_done");
        chk("post_rst_wr_cnt", 64'(a_wr_cnt - wb), 2048);
        chk("post_rst_order", 64'(a_ord_err - ob), 0);
        chk("post_rst_big_mul_all", 64'(scan_a(3, 0)), 0);

        // Small config, reserved op behaves as mul, wide operands
        b_mode = 3; rb = b_ordy_cnt; wb = b_wr_cnt; ob = b_ord_err;
        go_b(2'd3, s);
        wait_b(rb, "b_done");
        chk("b_wr_cnt", 64'(b_wr_cnt - wb), 16);
        chk("b_order", 64'(b_ord_err - ob), 0);
        chk("b_first_wr", 64'(b_first), 64'(s + 5));
        chk("b_ordy_cyc", 64'(b_ordy_cyc), 64'(s + 21));
        chk("b_mw_rise", 64'(b_mw_rise), 64'(s + 19));
        chk("b_mul_all", 64'(scan_b(3, 0)), 0);

        b_mode = 0; rb = b_ordy_cnt;
        go_b(2'd0, s);
        wait_b(rb, "b_sq_done");
        chk("b_r5_l0", b_res[5][31:0], 25);
        chk("b_r5_l1", b_res[5][63:32], 441);
        chk("b_r5_l2", b_res[5][95:64], 1369);
        chk("b_r5_l3", b_res[5][127:96], 2809);
        chk("b_r15_l3", b_res[15][127:96], 3969);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
